// File: rtl/elevator_call_conditioner_if.sv
// Signal bundle between the call-button conditioner and its surroundings.
// The wdog_fault member exists only when REQ_WATCHDOG_EN is defined.
interface elevator_call_conditioner_if;
    logic raw_call_1;
    logic raw_call_2;
    logic raw_hold;
    logic at_floor_1;
    logic at_floor_2;
    logic button_1;
    logic button_2;
    logic hold;
    logic pending_1;
    logic pending_2;
`ifdef REQ_WATCHDOG_EN
    logic wdog_fault;

    modport master (
        output raw_call_1, raw_call_2, raw_hold, at_floor_1, at_floor_2,
        input  button_1, button_2, hold, pending_1, pending_2, wdog_fault
    );

    modport slave (
        input  raw_call_1, raw_call_2, raw_hold, at_floor_1, at_floor_2,
        output button_1, button_2, hold, pending_1, pending_2, wdog_fault
    );
`else
    modport master (
        output raw_call_1, raw_call_2, raw_hold, at_floor_1, at_floor_2,
        input  button_1, button_2, hold, pending_1, pending_2
    );

    modport slave (
        input  raw_call_1, raw_call_2, raw_hold, at_floor_1, at_floor_2,
        output button_1, button_2, hold, pending_1, pending_2
    );
`endif
endinterface

// File: rtl/elevator_call_conditioner.sv
// Synchronises/debounces elevator buttons, latches calls and sequences the 2-floor controller.
// Optional request watchdog (wdog_fault) is built when REQ_WATCHDOG_EN is defined.
module elevator_call_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
`ifdef REQ_WATCHDOG_EN
    parameter int unsigned WDOG_CYCLES     = 1024,
`endif
    parameter int unsigned DWELL_CYCLES    = 64
) (
    input logic                        clk,
    input logic                        reset,
    elevator_call_conditioner_if.slave bus
);

    localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned DwW = $clog2(DWELL_CYCLES + 1);

    typedef enum logic [2:0] {StIdle, StReq, StDwell, StRelease, StWait} state_e;

    // Input index: 0 = call floor 1, 1 = call floor 2, 2 = hold button
    logic [2:0]     raw;
    logic [2:0]     sync1_q, sync2_q;
    logic [2:0]     deb_q, deb_prev_q;
    logic [2:0]     rise;
    logic [DbW-1:0] cnt_q [3];

    logic           af1, af2, none_at;
    logic [1:0]     pend_q, pend_d;
    logic [1:0]     wd_clr;

    state_e         state_q, state_d;
    logic           tgt_q, tgt_d;  // 0 = floor 1, 1 = floor 2
    logic           rr_q, rr_d;    // round-robin pointer, 0 selects floor 1
    logic [DwW-1:0] dwell_q, dwell_d;
    logic [1:0]     button_q, button_d;
    logic           hold_q, hold_d;
    logic           arrived, other_pending;

`ifdef REQ_WATCHDOG_EN
    localparam int unsigned WdW = $clog2(WDOG_CYCLES + 1);
    logic [WdW-1:0] wdog_cnt_q, wdog_cnt_d;
    logic           fault_q, fault_d;
`endif

    assign raw = {bus.raw_hold, bus.raw_call_2, bus.raw_call_1};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q    <= raw;
            sync2_q    <= sync1_q;
            deb_prev_q <= deb_q;
            for (int i = 0; i < 3; i++) begin
                if (sync2_q[i] == deb_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == DbW'(DEBOUNCE_CYCLES)) begin
                    deb_q[i] <= ~deb_q[i];
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + DbW'(1);
                end
            end
        end
    end

    assign rise = deb_q & ~deb_prev_q;

    // Both floor flags high is nonsensical feedback and counts as no floor
    assign af1     = bus.at_floor_1 & ~bus.at_floor_2;
    assign af2     = bus.at_floor_2 & ~bus.at_floor_1;
    assign none_at = ~af1 & ~af2;

    // Arrival clear beats a new call; a call for the occupied floor is never latched
    assign pend_d[0] = (pend_q[0] | rise[0]) & ~af1 & ~wd_clr[0];
    assign pend_d[1] = (pend_q[1] | rise[1]) & ~af2 & ~wd_clr[1];

    assign arrived       = tgt_q ? af2 : af1;
    assign other_pending = tgt_q ? pend_q[0] : pend_q[1];

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        rr_d    = rr_q;
        dwell_d = dwell_q;
        wd_clr  = '0;
`ifdef REQ_WATCHDOG_EN
        wdog_cnt_d = wdog_cnt_q;
        fault_d    = fault_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (none_at && (pend_q != 2'b00)) begin
                    if (pend_q == 2'b11) begin
                        tgt_d = rr_q;
                        rr_d  = ~rr_q;
                    end else begin
                        tgt_d = pend_q[1];
                    end
                    state_d = StReq;
`ifdef REQ_WATCHDOG_EN
                    wdog_cnt_d = '0;
`endif
                end
            end
            StReq: begin
                if (arrived) begin
                    dwell_d = DwW'(DWELL_CYCLES);
                    state_d = StDwell;
`ifdef REQ_WATCHDOG_EN
                end else if (wdog_cnt_q == WdW'(WDOG_CYCLES - 1)) begin
                    fault_d       = 1'b1;
                    wd_clr[tgt_q] = 1'b1;
                    state_d       = StIdle;
                end else begin
                    wdog_cnt_d = wdog_cnt_q + WdW'(1);
`endif
                end
            end
            StDwell: begin
                if (rise[2] || ((dwell_q == '0) && other_pending)) begin
                    state_d = StRelease;
                end else if (dwell_q != '0) begin
                    dwell_d = dwell_q - DwW'(1);
                end
            end
            StRelease: state_d = StWait;
            StWait: begin
                if (none_at) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Outputs registered from the next state so they are glitch-free levels
        button_d[0] = (state_d == StReq) && !tgt_d;
        button_d[1] = (state_d == StReq) && tgt_d;
        hold_d      = (state_d == StRelease);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            tgt_q    <= 1'b0;
            rr_q     <= 1'b0;
            dwell_q  <= '0;
            pend_q   <= '0;
            button_q <= '0;
            hold_q   <= 1'b0;
`ifdef REQ_WATCHDOG_EN
            wdog_cnt_q <= '0;
            fault_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            tgt_q    <= tgt_d;
            rr_q     <= rr_d;
            dwell_q  <= dwell_d;
            pend_q   <= pend_d;
            button_q <= button_d;
            hold_q   <= hold_d;
`ifdef REQ_WATCHDOG_EN
            wdog_cnt_q <= wdog_cnt_d;
            fault_q    <= fault_d;
`endif
        end
    end

    assign bus.button_1  = button_q[0];
    assign bus.button_2  = button_q[1];
    assign bus.hold      = hold_q;
    assign bus.pending_1 = pend_q[0];
    assign bus.pending_2 = pend_q[1];
`ifdef REQ_WATCHDOG_EN
    assign bus.wdog_fault = fault_q;
`endif

endmodule
